lcd_serial_rgb_driver: RTL and testbench
========================================

// Module: lcd_serial_rgb_driver
// PURPOSE
//  Timing generator and pixel serialiser for the 8-bit serial-RGB LCD panel, running on the 20.2 MHz PLL pixel clock.
//  Sits between a pixel source (pattern generator / framebuffer reader) and the lcd_dat/hsync/vsync/den pins.
//  Fetches one 24-bit pixel per pixel slot via a request interface.
//  Emits it as three consecutive bytes R,G,B with aligned sync and data-enable.
// PARAMETERS
//  H_ACTIVE   320  active pixels per line (each pixel = 3 clocks)
//  H_FP        20  horizontal front porch, pixels
//  H_SYNC      30  hsync width, pixels
//  H_BP        38  horizontal back porch, pixels (H_TOTAL = 408 -> 1224 clk/line)
//  V_ACTIVE   240  active lines
//  V_FP         4  vertical front porch, lines
//  V_SYNC       3  vsync width, lines
//  V_BP        15  vertical back porch, lines (V_TOTAL = 262 -> ~63 Hz)
//  SYNC_NEG     1  1: hsync/vsync active-low; 0: active-high
// PORTS
//  clk         in   1   pixel clock (20.2 MHz); single clock domain
//  resetn      in   1   asynchronous, active-low reset
//  pix_req     out  1   pixel fetch strobe, one clk per active pixel slot
//  pix_x       out  9   column of requested pixel, valid when pix_req=1
//  pix_y       out  8   row of requested pixel, valid when pix_req=1
//  pix_rgb     in   24  {R,G,B} from source; must be valid exactly 1 clk after pix_req
//  frame_start out  1   1-clk pulse at counter origin (x=0,y=0,phase 0)
//  lcd_dat     out  8   serial colour byte
//  lcd_hsync   out  1   horizontal sync
//  lcd_vsync   out  1   vertical sync
//  lcd_den     out  1   data enable, high for active bytes only
// BEHAVIOUR
//  - Counters:
//    - phase 0..2 increments every clk.
//    - h_cnt 0..H_TOTAL-1 increments when phase wraps 2->0.
//    - v_cnt 0..V_TOTAL-1 increments when h_cnt wraps.
//    - All counters wrap to 0 together at end of frame.
//  - Line order from h_cnt=0: active, FP, sync, BP. Same for lines from v_cnt=0.
//  - Stage 0 (counter regs, decoded directly, no extra register):
//    - pix_req = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)&&(phase==0).
//    - pix_x = h_cnt; pix_y = v_cnt.
//    - frame_start = (h,v,phase)==(0,0,0).
//  - Stage 1: pix_rgb captured into a 24-bit hold register on the clk after pix_req. pix_rgb is ignored at all other times.
//  - Stage 2: lcd_dat registered from hold reg, selecting R/G/B by phase delayed 1 clk. lcd_dat = 8'h00 whenever lcd_den=0.
//  - hsync/vsync/den are decoded in stage 0 and delayed 2 clks, so they are byte-aligned with lcd_dat.
//    - Latency: pix_req at t -> R at t+2, G at t+3, B at t+4.
//  - hsync asserts during h sync pixels on every line, including vblank.
//  - vsync asserts for whole lines v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//  - Reset (async assert, any time, including mid-line):
//    - counters = 0; pipeline cleared.
//    - lcd_dat = 0, lcd_den = 0, pix_req = 0.
//    - syncs inactive (high if SYNC_NEG).
//  - Reset exit: first clk after deassertion is counter origin.
//    - frame_start = 1, pix_req(0,0) = 1.
//    - Delay-line syncs/den read inactive for the first 2 clks.
//  - No backpressure: the source must always meet the 1-clk latency.
// STRUCTURE
//  - Shared include lcd_timing_defs.vh: default porch/sync constants, H_TOTAL/V_TOTAL derivations, counter widths.
//  - One sub-module, lcd_timing_counter: phase/h/v counters plus region decodes.
//  - Top-level logic: fetch, hold register, byte mux, 2-stage delay lines.
// TESTING
//  1. Hold resetn=0 -> lcd_den=0, lcd_dat=00, hsync=vsync=1, pix_req=0.
//     Release -> frame_start=1 and pix_req=1 with x=0, y=0 on first clk.
//  2. Drive pix_rgb=A1B2C3 the clk after the first pix_req -> lcd_dat=A1,B2,C3 on clks 2,3,4 with den=1.
//  3. Count a line -> 1224 clks between hsync falls.
//     den high 960 clks, then low; hsync low 90 clks beginning 1020 clks after the first den rise.
//  4. Full frame -> frame_start period 320688 clks.
//     vsync low exactly 3 lines, beginning line 244; den=0 and pix_req=0 throughout lines 240-261.
//  5. Toggle pix_rgb on non-request clks -> lcd_dat unaffected. Last pixel x=319, y=239 is requested and emitted.
//  6. Assert resetn mid-active at x=150 -> outputs idle in the same clk.
//     After release, restart at origin; no stale bytes appear.

Source files
------------

// File: rtl/lcd_serial_rgb_driver_pkg.sv
// Shared timing constants, counter types and small helpers for the
// serial-RGB LCD driver. The default porch/sync values describe the
// 320x240 panel; H_TOTAL = 408 pixels (1224 clk), V_TOTAL = 262 lines.
package lcd_serial_rgb_driver_pkg;

    // Counter widths: 9 bits cover 0..407 horizontally and 0..261 vertically.
    localparam int unsigned H_CNT_W = 9;
    localparam int unsigned V_CNT_W = 9;

    typedef logic [H_CNT_W-1:0] hcnt_t;
    typedef logic [V_CNT_W-1:0] vcnt_t;

    // Default horizontal timing, in pixels (one pixel = three clocks).
    localparam hcnt_t H_ACTIVE_DEF = 9'd320;
    localparam hcnt_t H_FP_DEF     = 9'd20;
    localparam hcnt_t H_SYNC_DEF   = 9'd30;
    localparam hcnt_t H_BP_DEF     = 9'd38;

    // Default vertical timing, in lines.
    localparam vcnt_t V_ACTIVE_DEF = 9'd240;
    localparam vcnt_t V_FP_DEF     = 9'd4;
    localparam vcnt_t V_SYNC_DEF   = 9'd3;
    localparam vcnt_t V_BP_DEF     = 9'd15;

    // Byte slot within a pixel: R, G, B go out on consecutive clocks.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    // Half-open window test [lo, hi) used for the sync regions.
    function automatic logic in_window(input logic [8:0] cnt,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/lcd_serial_rgb_driver_timing_counter.sv
// Phase / horizontal / vertical counters of the LCD raster plus the
// region decodes derived directly from them (no extra register stage).
module lcd_serial_rgb_driver_timing_counter
    import lcd_serial_rgb_driver_pkg::*;
#(
    parameter hcnt_t H_ACTIVE = H_ACTIVE_DEF,
    parameter hcnt_t H_FP     = H_FP_DEF,
    parameter hcnt_t H_SYNC   = H_SYNC_DEF,
    parameter hcnt_t H_BP     = H_BP_DEF,
    parameter vcnt_t V_ACTIVE = V_ACTIVE_DEF,
    parameter vcnt_t V_FP     = V_FP_DEF,
    parameter vcnt_t V_SYNC   = V_SYNC_DEF,
    parameter vcnt_t V_BP     = V_BP_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output phase_e     phase_o,
    output logic [8:0] x_o,
    output logic [7:0] y_o,
    output logic       active_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       origin_o
);

    // Line order from 0: active, front porch, sync, back porch.
    localparam hcnt_t H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam hcnt_t H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam hcnt_t H_TOTAL    = H_SYNC_END + H_BP;
    localparam vcnt_t V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam vcnt_t V_SYNC_END = V_SYNC_BEG + V_SYNC;
    localparam vcnt_t V_TOTAL    = V_SYNC_END + V_BP;

    phase_e phase_q, phase_d;
    hcnt_t  h_cnt_q, h_cnt_d;
    vcnt_t  v_cnt_q, v_cnt_d;

    // Next-state: phase steps every clock, h on phase wrap, v on h wrap.
    always_comb begin
        phase_d = phase_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (phase_q)
            PH_R:    phase_d = PH_G;
            PH_G:    phase_d = PH_B;
            default: phase_d = PH_R;
        endcase
        if (phase_q == PH_B) begin
            if (h_cnt_q == H_TOTAL - 9'd1) begin
                h_cnt_d = 9'd0;
                if (v_cnt_q == V_TOTAL - 9'd1) begin
                    v_cnt_d = 9'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 9'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 9'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Counter registers; reset places the raster at its origin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_R;
            h_cnt_q <= 9'd0;
            v_cnt_q <= 9'd0;
        end else begin
            phase_q <= phase_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign phase_o  = phase_q;
    assign x_o      = h_cnt_q;
    assign y_o      = v_cnt_q[7:0];
    assign active_o = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
    assign hsync_o  = in_window(h_cnt_q, H_SYNC_BEG, H_SYNC_END);
    assign vsync_o  = in_window(v_cnt_q, V_SYNC_BEG, V_SYNC_END);
    assign origin_o = (h_cnt_q == 9'd0) && (v_cnt_q == 9'd0) && (phase_q == PH_R);

endmodule

// File: rtl/lcd_serial_rgb_driver.sv
// Serial-RGB LCD driver: raster timing, pixel fetch, hold register,
// R/G/B byte serialiser and the two-stage delay lines that keep
// hsync/vsync/den byte-aligned with lcd_dat.
// Latency: pix_req at t -> R at t+2, G at t+3, B at t+4.
module lcd_serial_rgb_driver
    import lcd_serial_rgb_driver_pkg::*;
#(
    parameter hcnt_t H_ACTIVE = H_ACTIVE_DEF,
    parameter hcnt_t H_FP     = H_FP_DEF,
    parameter hcnt_t H_SYNC   = H_SYNC_DEF,
    parameter hcnt_t H_BP     = H_BP_DEF,
    parameter vcnt_t V_ACTIVE = V_ACTIVE_DEF,
    parameter vcnt_t V_FP     = V_FP_DEF,
    parameter vcnt_t V_SYNC   = V_SYNC_DEF,
    parameter vcnt_t V_BP     = V_BP_DEF,
    parameter logic  SYNC_NEG = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        pix_req,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    input  logic [23:0] pix_rgb,
    output logic        frame_start,
    output logic [7:0]  lcd_dat,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_den
);

    phase_e phase_s;
    logic   active_s;
    logic   hsync_raw_s;
    logic   vsync_raw_s;
    logic   origin_s;

    lcd_serial_rgb_driver_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i    (clk),
        .rst_ni   (resetn),
        .phase_o  (phase_s),
        .x_o      (pix_x),
        .y_o      (pix_y),
        .active_o (active_s),
        .hsync_o  (hsync_raw_s),
        .vsync_o  (vsync_raw_s),
        .origin_o (origin_s)
    );

    // Stage 0 strobes come straight off the counters. They are gated by
    // resetn so they read idle while reset is held, even though the
    // counters already sit at the origin.
    assign pix_req     = resetn & active_s & (phase_s == PH_R);
    assign frame_start = resetn & origin_s;

    // Stage 1 registers
    logic   req1_q,   req1_d;
    logic   den1_q,   den1_d;
    logic   hs1_q,    hs1_d;
    logic   vs1_q,    vs1_d;
    phase_e phase1_q, phase1_d;
    logic [23:0] hold_q, hold_d;
    // Stage 2 registers (drive the pins)
    logic [7:0] dat_q, dat_d;
    logic   den2_q,   den2_d;
    logic   hs2_q,    hs2_d;
    logic   vs2_q,    vs2_d;
    logic [7:0] byte_s;

    // Byte mux: the R byte is taken straight from pix_rgb in the clock it
    // arrives (the hold register is loading in parallel); G and B come
    // from the hold register on the following clocks.
    always_comb begin
        byte_s = 8'h00;
        case (phase1_q)
            PH_R:    byte_s = pix_rgb[23:16];
            PH_G:    byte_s = hold_q[15:8];
            PH_B:    byte_s = hold_q[7:0];
            default: byte_s = 8'h00;
        endcase
    end

    // Next-state for both pipeline stages; syncs are held at pin level.
    always_comb begin
        req1_d   = pix_req;
        den1_d   = active_s;
        hs1_d    = hsync_raw_s ^ SYNC_NEG;
        vs1_d    = vsync_raw_s ^ SYNC_NEG;
        phase1_d = phase_s;
        hold_d   = hold_q;
        if (req1_q) begin
            hold_d = pix_rgb;
        end else begin
            hold_d = hold_q;
        end
        den2_d = den1_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        if (den1_q) begin
            dat_d = byte_s;
        end else begin
            dat_d = 8'h00;
        end
    end

    // Pipeline registers; reset clears data/den and parks syncs inactive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req1_q   <= 1'b0;
            den1_q   <= 1'b0;
            hs1_q    <= SYNC_NEG;
            vs1_q    <= SYNC_NEG;
            phase1_q <= PH_R;
            hold_q   <= 24'h000000;
            dat_q    <= 8'h00;
            den2_q   <= 1'b0;
            hs2_q    <= SYNC_NEG;
            vs2_q    <= SYNC_NEG;
        end else begin
            req1_q   <= req1_d;
            den1_q   <= den1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            phase1_q <= phase1_d;
            hold_q   <= hold_d;
            dat_q    <= dat_d;
            den2_q   <= den2_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
        end
    end

    assign lcd_dat   = dat_q;
    assign lcd_den   = den2_q;
    assign lcd_hsync = hs2_q;
    assign lcd_vsync = vs2_q;

endmodule

// File: tb/tb_lcd_serial_rgb_driver.sv
// Bench for lcd_serial_rgb_driver. Horizontal timing is the panel default
// (1224 clk/line); the vertical timing is shortened to 16 lines so whole
// frames fit in a short run. Expected values come from a position model:
// clocks since reset release -> (line, pixel, byte) by division.
module tb_lcd_serial_rgb_driver;

    localparam int HA = 320, HF = 20, HS = 30, HB = 38;
    localparam int VA = 8,   VF = 2,  VS = 3,  VB = 3;
    localparam int HT = HA + HF + HS + HB;     // 408 pixels
    localparam int VT = VA + VF + VS + VB;     // 16 lines
    localparam int LINE  = HT * 3;             // 1224 clocks
    localparam int FRAME = LINE * VT;          // 19584 clocks

    logic        clk = 1'b0;
    logic        resetn;
    logic        pix_req;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic [7:0]  lcd_dat;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_den;

    lcd_serial_rgb_driver #(
        .H_ACTIVE (9'd320), .H_FP (9'd20), .H_SYNC (9'd30), .H_BP (9'd38),
        .V_ACTIVE (9'd8),   .V_FP (9'd2),  .V_SYNC (9'd3),  .V_BP (9'd3),
        .SYNC_NEG (1'b1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .lcd_dat     (lcd_dat),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_den     (lcd_den)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int n = 0;          // clocks since reset release (0 = origin clock)
    bit live = 1'b0;    // reset released
    int seg = 0;        // number of reset releases so far
    bit req_last = 1'b0;
    int x_last = 0, y_last = 0;

    // Measurements taken during the first run after reset
    logic hs_prev = 1'b1, vs_prev = 1'b1, den_prev = 1'b0;
    int hs_falls = 0, hs_fall0 = 0, hs_fall1 = 0, hs_low_run = 0;
    int vs_falls = 0, vs_fall0 = 0, vs_low_run = 0;
    int den_rises = 0, den_rise0 = 0, den_run = 0;
    int fs_cnt = 0, fs_t0 = 0, fs_t1 = 0;
    int vblank_busy = 0;
    bit last_seen = 1'b0;

    // Pixel source content; pixel (0,0) is the fixed A1B2C3 test colour.
    function automatic logic [23:0] src_rgb(input int x, input int y);
        if (x == 0 && y == 0) return 24'hA1B2C3;
        return {8'(x * 7 + y), 8'(x ^ (y * 16)), 8'(255 - x - y * 3)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s seg=%0d n=%0d: got %0h expected %0h", name, seg, n, act, exp);
        end
    endtask

    task automatic check_cycle();
        int pos, line, col, px, ph, q;
        int e_den, e_hs, e_vs, e_dat;
        logic [23:0] c;
        if (!live) begin
            chk("rst_pix_req", int'(pix_req), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_den", int'(lcd_den), 0);
            chk("rst_dat", int'(lcd_dat), 0);
            chk("rst_hsync", int'(lcd_hsync), 1);
            chk("rst_vsync", int'(lcd_vsync), 1);
        end else begin
            // Stage 0: raster position of this very clock
            pos  = n % FRAME;
            line = pos / LINE;
            col  = pos % LINE;
            px   = col / 3;
            ph   = col % 3;
            chk("pix_req", int'(pix_req), int'(line < VA && px < HA && ph == 0));
            chk("frame_start", int'(frame_start), int'(pos == 0));
            if (line < VA && px < HA && ph == 0) begin
                chk("pix_x", int'(pix_x), px);
                chk("pix_y", int'(pix_y), line);
            end
            // Pins: position two clocks earlier, idle before that exists
            e_den = 0; e_hs = 1; e_vs = 1; e_dat = 0;
            if (n >= 2) begin
                q    = (n - 2) % FRAME;
                line = q / LINE;
                col  = q % LINE;
                px   = col / 3;
                ph   = col % 3;
                e_den = int'(line < VA && px < HA);
                e_hs  = int'(!(px >= HA + HF && px < HA + HF + HS));
                e_vs  = int'(!(line >= VA + VF && line < VA + VF + VS));
                if (e_den != 0) begin
                    c = src_rgb(px, line);
                    if (ph == 0) e_dat = int'(c[23:16]);
                    else if (ph == 1) e_dat = int'(c[15:8]);
                    else e_dat = int'(c[7:0]);
                end
            end
            chk("lcd_den", int'(lcd_den), e_den);
            chk("lcd_hsync", int'(lcd_hsync), e_hs);
            chk("lcd_vsync", int'(lcd_vsync), e_vs);
            chk("lcd_dat", int'(lcd_dat), e_dat);
            // Hand-computed anchors at the start of every run
            if (n == 0) begin
                chk("origin_frame_start", int'(frame_start), 1);
                chk("origin_pix_req", int'(pix_req), 1);
                chk("origin_xy", int'({pix_x, pix_y}), 0);
                chk("origin_den_idle", int'(lcd_den), 0);
            end
            if (n == 2) chk("first_R", int'(lcd_dat), 32'hA1);
            if (n == 3) chk("first_G", int'(lcd_dat), 32'hB2);
            if (n == 4) chk("first_B", int'(lcd_dat), 32'hC3);
            if (n >= 2 && n <= 4) chk("first_den", int'(lcd_den), 1);
            if (seg == 1) begin
                if (hs_prev && !lcd_hsync) begin
                    if (hs_falls == 0) hs_fall0 = n;
                    if (hs_falls == 1) hs_fall1 = n;
                    hs_falls++;
                end
                if (!lcd_hsync && hs_falls == 1) hs_low_run++;
                if (vs_prev && !lcd_vsync) begin
                    if (vs_falls == 0) vs_fall0 = n;
                    vs_falls++;
                end
                if (!lcd_vsync && vs_falls == 1) vs_low_run++;
                if (!den_prev && lcd_den) begin
                    if (den_rises == 0) den_rise0 = n;
                    den_rises++;
                end
                if (lcd_den && den_rises == 1) den_run++;
                if (frame_start) begin
                    if (fs_cnt == 0) fs_t0 = n;
                    if (fs_cnt == 1) fs_t1 = n;
                    fs_cnt++;
                end
                pos = n % FRAME;
                if (pos >= VA * LINE && pix_req) vblank_busy++;
                if (pos >= VA * LINE + 2 && lcd_den) vblank_busy++;
                if (pix_req && pix_x == 9'd319 && pix_y == 8'd7) last_seen = 1'b1;
            end
        end
        hs_prev  = lcd_hsync;
        vs_prev  = lcd_vsync;
        den_prev = lcd_den;
    endtask

    // One clock: update reset and the source just after the rising edge,
    // then check everything at the falling edge.
    task automatic step(input logic rst_v);
        @(posedge clk);
        #1;
        if (!rst_v) begin
            resetn = 1'b0;
            live   = 1'b0;
            n      = 0;
        end else if (!live) begin
            resetn = 1'b1;
            live   = 1'b1;
            n      = 0;
            seg++;
        end else begin
            n++;
        end
        // Source answers the previous request; any other clock carries junk.
        if (live && req_last) pix_rgb = src_rgb(x_last, y_last);
        else pix_rgb = 24'($urandom);
        @(negedge clk);
        check_cycle();
        req_last = live && pix_req;
        x_last   = int'(pix_x);
        y_last   = int'(pix_y);
    endtask

    initial begin
        resetn  = 1'b0;
        pix_rgb = 24'h000000;
        repeat (4) step(1'b0);
        // Run one full frame, then into line 1 of the next up to x=150.
        repeat (FRAME + LINE + 150 * 3 + 1) step(1'b1);
        chk("pre_reset_den", int'(lcd_den), 1);
        repeat (3) step(1'b0);
        repeat (2 * LINE + 10) step(1'b1);

        chk("hsync_period", hs_fall1 - hs_fall0, 1224);
        chk("den_high_run", den_run, 960);
        chk("hsync_low_run", hs_low_run, 90);
        chk("hsync_after_den", hs_fall0 - den_rise0, 1020);
        chk("frame_period", fs_t1 - fs_t0, 19584);
        chk("vsync_start", vs_fall0, 10 * 1224 + 2);
        chk("vsync_low_run", vs_low_run, 3 * 1224);
        chk("vblank_busy", vblank_busy, 0);
        chk("last_pixel_req", int'(last_seen), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
